data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 180 ++++++++++++++++++
 tb/tb_data_cache.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Loads and store hits complete without a stall; misses go through WRITEBACK/ALLOCATE/UPDATE.
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          READ,
    input  logic          WRITE,
    input  logic [2:0]    FUNCT3,
    input  logic [31:0]   ADDRESS,
    input  logic [31:0]   WRITEDATA,
    output logic [31:0]   READDATA,
    output logic          BUSYWAIT,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [27:0]   MEM_ADDRESS,
    output logic [127:0]  MEM_WRITEDATA,
    input  logic [127:0]  MEM_READDATA,
    input  logic          MEM_BUSYWAIT
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];

    logic [3:0]            off;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      atag;
    logic [TAG_W-1:0]      stag;
    logic [127:0]          line;
    logic                  hit;
    logic                  rd_req;
    logic                  wr_req;
    logic                  store_hit;
    logic                  load_hit;
    logic                  fill;
    logic [15:0]           be;
    logic [127:0]          wline;
    logic [31:0]           rword;
    logic [15:0]           rhalf;
    logic [7:0]            rbyte;

    assign off    = ADDRESS[3:0];
    assign idx    = ADDRESS[3+INDEX_BITS:4];
    assign atag   = ADDRESS[31:4+INDEX_BITS];
    assign stag   = tag_q[idx];
    assign line   = data_q[idx];
    assign hit    = valid_q[idx] && (stag == atag);

    // READ and WRITE together are treated as no request at all
    assign rd_req = READ && !WRITE;
    assign wr_req = WRITE && !READ;

    assign store_hit = (state_q == IDLE) && wr_req && hit;
    assign load_hit  = (state_q == IDLE) && rd_req && hit;
    assign fill      = (state_q == UPDATE);

    // Byte enables and merged line for a store; sub-word address bits are ignored
    always_comb begin
        be    = '0;
        wline = line;
        case (FUNCT3[1:0])
            2'b00:   be[off] = 1'b1;
            2'b01:   be[{off[3:1], 1'b0} +: 2] = 2'b11;
            default: be[{off[3:2], 2'b00} +: 4] = 4'hF;
        endcase
        for (int k = 0; k < 16; k++) begin
            if (be[k]) begin
                case (FUNCT3[1:0])
                    2'b00:   wline[8*k +: 8] = WRITEDATA[7:0];
                    2'b01:   wline[8*k +: 8] = WRITEDATA[8*(k%2) +: 8];
                    default: wline[8*k +: 8] = WRITEDATA[8*(k%4) +: 8];
                endcase
            end
        end
    end

    assign rword = line[{off[3:2], 5'b0} +: 32];
    assign rhalf = line[{off[3:1], 4'b0} +: 16];
    assign rbyte = line[{off, 3'b0} +: 8];

    // Load result, size-selected and extended; zero unless a load hits
    always_comb begin
        READDATA = '0;
        if (load_hit) begin
            case (FUNCT3)
                3'b000:  READDATA = {{24{rbyte[7]}}, rbyte};
                3'b001:  READDATA = {{16{rhalf[15]}}, rhalf};
                3'b100:  READDATA = {24'b0, rbyte};
                3'b101:  READDATA = {16'b0, rhalf};
                default: READDATA = rword;
            endcase
        end
    end

    // Miss-handling FSM: next state and memory handshake outputs
    always_comb begin
        state_d   = state_q;
        BUSYWAIT  = 1'b1;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        unique case (state_q)
            IDLE: begin
                BUSYWAIT = (rd_req || wr_req) && !hit;
                if ((rd_req || wr_req) && !hit) begin
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                MEM_WRITE = 1'b1;
                if (!MEM_BUSYWAIT) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The victim uses its stored tag; a fetch uses the requested tag
    assign MEM_ADDRESS   = (state_q == WRITEBACK) ? {stag, idx} : {atag, idx};
    assign MEM_WRITEDATA = line;

    // Valid/dirty updates: store hits dirty the line, a fill leaves it clean
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (store_hit) dirty_d[idx] = 1'b1;
        if (fill) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
    end

    // State and line status registers, cleared by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[idx] <= MEM_READDATA;
            tag_q[idx]  <= atag;
        end else if (store_hit) begin
            data_q[idx] <= wline;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a latency-programmable block memory.
// Covers fills, store hits, sign/zero extension, write-back and reset mid-miss.
module tb_data_cache;

    logic          CLK;
    logic          RESET;
    logic          READ;
    logic          WRITE;
    logic [2:0]    FUNCT3;
    logic [31:0]   ADDRESS;
    logic [31:0]   WRITEDATA;
    logic [31:0]   READDATA;
    logic          BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [27:0]   MEM_ADDRESS;
    logic [127:0]  MEM_WRITEDATA;
    logic [127:0]  MEM_READDATA;
    logic          MEM_BUSYWAIT;

    logic [127:0]  mem [256];
    int            lat = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            rd_done = 0;
    int            wr_done = 0;
    logic          both_seen = 1'b0;
    logic [127:0]  wb_last = '0;

    int n_chk = 0;
    int n_pass = 0;

    data_cache #(.INDEX_BITS(3)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .FUNCT3        (FUNCT3),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory stays busy for 'lat' cycles of each held request
    assign MEM_BUSYWAIT = (MEM_READ && rd_cnt < lat) ||
                          (MEM_WRITE && wr_cnt < lat);
    assign MEM_READDATA = mem[MEM_ADDRESS[7:0]];

    // Request timers, completion counters and write-back capture
    always @(posedge CLK) begin
        rd_cnt <= MEM_READ ? rd_cnt + 1 : 0;
        wr_cnt <= MEM_WRITE ? wr_cnt + 1 : 0;
        if (MEM_READ && !MEM_BUSYWAIT) rd_done <= rd_done + 1;
        if (MEM_WRITE && !MEM_BUSYWAIT) begin
            wr_done <= wr_done + 1;
            wb_last <= MEM_WRITEDATA;
        end
        if (MEM_READ && MEM_WRITE) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        READ      = rd;
        WRITE     = wr;
        FUNCT3    = f3;
        ADDRESS   = a;
        WRITEDATA = wd;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (BUSYWAIT && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk(tag, {31'b0, BUSYWAIT}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h04] = 128'h00000000_00000000_A5A5A5A5_DEADBEEF;
        mem[8'h84] = 128'h00000000_00000000_55667788_CAFEF00D;
        mem[8'h03] = 128'h00000000_00000000_00000000_0BADC0DE;

        RESET = 1'b0;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        chk("rst_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("rst_mrd", {31'b0, MEM_READ}, 32'd0);
        chk("rst_mwr", {31'b0, MEM_WRITE}, 32'd0);
        chk("rst_rdata", READDATA, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        // Cold miss fill of index 4
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        #1;
        chk("a_miss_busy", {31'b0, BUSYWAIT}, 32'd1);
        chk("a_miss_rdata", READDATA, 32'd0);
        @(negedge CLK);
        #1;
        chk("a_alloc_mrd", {31'b0, MEM_READ}, 32'd1);
        chk("a_alloc_mwr", {31'b0, MEM_WRITE}, 32'd0);
        chk("a_alloc_addr", {4'b0, MEM_ADDRESS}, 32'h4);
        wait_ready("a_ready");
        chk("a_lw", READDATA, 32'hDEADBEEF);

        // Byte store hit, then signed/unsigned byte loads
        @(negedge CLK);
        drive(1'b0, 1'b1, 3'b000, 32'h41, 32'h80);
        #1;
        chk("b_sb_busy", {31'b0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b000, 32'h41, 32'h0);
        #1;
        chk("b_lb", READDATA, 32'hFFFFFF80);
        FUNCT3 = 3'b100;
        #1;
        chk("b_lbu", READDATA, 32'h00000080);
        FUNCT3 = 3'b010;
        ADDRESS = 32'h40;
        #1;
        chk("b_lw", READDATA, 32'hDEAD80EF);

        // Word store hit, then a conflicting miss forces a write-back
        @(negedge CLK);
        drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
        #1;
        chk("c_sw_busy", {31'b0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        lat = 5;
        drive(1'b1, 1'b0, 3'b010, 32'h840, 32'h0);
        #1;
        chk("c_miss_busy", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        #1;
        chk("c_wb_mwr", {31'b0, MEM_WRITE}, 32'd1);
        chk("c_wb_mrd", {31'b0, MEM_READ}, 32'd0);
        chk("c_wb_addr", {4'b0, MEM_ADDRESS}, 32'h4);
        chk("c_wb_w0", MEM_WRITEDATA[31:0], 32'h12345678);
        chk("c_wb_w1", MEM_WRITEDATA[63:32], 32'hA5A5A5A5);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            chk("c_wb_hold", {29'b0, MEM_WRITE, MEM_BUSYWAIT, BUSYWAIT},
                32'd7);
        end
        @(negedge CLK);
        #1;
        chk("c_wb_last", {29'b0, MEM_WRITE, MEM_BUSYWAIT, BUSYWAIT}, 32'd5);
        @(negedge CLK);
        #1;
        chk("c_al_rw", {30'b0, MEM_READ, MEM_WRITE}, 32'd2);
        chk("c_al_addr", {4'b0, MEM_ADDRESS}, 32'h84);
        chk("c_wb_mem", wb_last[31:0], 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            chk("c_al_hold", {29'b0, MEM_READ, MEM_BUSYWAIT, BUSYWAIT},
                32'd7);
        end
        wait_ready("c_ready");
        chk("c_lw", READDATA, 32'hCAFEF00D);
        chk("c_rd_done", rd_done, 32'd2);
        chk("c_wr_done", wr_done, 32'd1);

        // Halfword lanes, ignored low address bits, halfword store
        lat = 0;
        @(negedge CLK);
        drive(1'b0, 1'b1, 3'b000, 32'h842, 32'h34);
        @(negedge CLK);
        drive(1'b0, 1'b1, 3'b000, 32'h843, 32'hFFFFFF92);
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b001, 32'h842, 32'h0);
        #1;
        chk("d_lh", READDATA, 32'hFFFF9234);
        FUNCT3 = 3'b101;
        #1;
        chk("d_lhu", READDATA, 32'h00009234);
        FUNCT3 = 3'b001;
        ADDRESS = 32'h843;
        #1;
        chk("d_lh_odd", READDATA, 32'hFFFF9234);
        FUNCT3 = 3'b010;
        ADDRESS = 32'h841;
        #1;
        chk("d_lw_mis", READDATA, 32'h9234F00D);
        @(negedge CLK);
        drive(1'b0, 1'b1, 3'b001, 32'h844, 32'h1234ABCD);
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b010, 32'h844, 32'h0);
        #1;
        chk("d_sh_lw", READDATA, 32'h5566ABCD);

        // READ and WRITE together: no request
        @(negedge CLK);
        drive(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
        #1;
        chk("e_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("e_rdata", READDATA, 32'd0);
        @(negedge CLK);
        #1;
        chk("e_mem", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);

        // Reset during ALLOCATE drops the request and invalidates lines
        lat = 5;
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        #1;
        chk("f_miss_busy", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        #1;
        chk("f_alloc", {30'b0, MEM_READ, MEM_WRITE}, 32'd2);
        chk("f_alloc_addr", {4'b0, MEM_ADDRESS}, 32'h3);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("f_rst_mem", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
        READ = 1'b0;
        #1;
        chk("f_rst_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("f_rst_rdata", READDATA, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        lat = 0;
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b010, 32'h840, 32'h0);
        #1;
        chk("f_remiss", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        #1;
        chk("f_no_wb", {30'b0, MEM_READ, MEM_WRITE}, 32'd2);
        wait_ready("f_ready1");
        chk("f_refill", READDATA, 32'hCAFEF00D);
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        #1;
        chk("f_miss30", {31'b0, BUSYWAIT}, 32'd1);
        wait_ready("f_ready2");
        chk("f_lw30", READDATA, 32'h0BADC0DE);
        @(negedge CLK);
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        chk("g_excl", {31'b0, both_seen}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
